pc_redirect_control: RTL

PC_REDIRECT_CONTROL -- requirements
Module: pc_redirect_control

---
 rtl/pc_redirect_control_if.sv | 31 +++
 rtl/pc_redirect_control.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_redirect_control_if.sv
// Fetch-side control bundle between the pipeline (master) and the PC
// redirect controller (slave). CNT_W sizes the committed-redirect counter.
interface pc_redirect_control_if #(
  parameter int CNT_W = 16
);
  logic             branch_valid;
  logic [31:0]      branch_target;
  logic [31:0]      pc_plus4;
  logic             hazard_stall;
  logic             fetch_ready;
  logic             pc_write;
  logic [31:0]      pc_out;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             redirect_pending;
  logic [CNT_W-1:0] redirect_count;
  logic             proto_err;

  modport master (
    output branch_valid, branch_target, pc_plus4, hazard_stall, fetch_ready,
    input  pc_write, pc_out, ifid_write, ifid_flush, idex_flush,
           redirect_pending, redirect_count, proto_err
  );

  modport slave (
    input  branch_valid, branch_target, pc_plus4, hazard_stall, fetch_ready,
    output pc_write, pc_out, ifid_write, ifid_flush, idex_flush,
           redirect_pending, redirect_count, proto_err
  );
endinterface

// File: rtl/pc_redirect_control.sv
// PC redirect controller: chooses the next PC (sequential, branch target or
// a held target), drives IF/ID and ID/EX enables/flushes, and parks a taken
// branch in HOLD while instruction memory is not ready to accept it.
module pc_redirect_control #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  pc_redirect_control_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      held_target;
  logic [CNT_W-1:0] redirect_count;
  logic             proto_err;

  logic             pc_write;
  logic [31:0]      pc_out;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             capture;   // latch branch_target into held_target
  logic             commit;    // a redirect reached the PC this cycle
  logic             err_set;   // branch arrived while already holding

  // State register; reset always returns to RUN so a held redirect is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Held target, saturating redirect counter and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_target    <= 32'd0;
      redirect_count <= '0;
      proto_err      <= 1'b0;
    end else begin
      if (capture) begin
        held_target <= bus.branch_target;
      end
      if (commit && (redirect_count != {CNT_W{1'b1}})) begin
        redirect_count <= redirect_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Next state and zero-latency pipeline controls; all quiet while in reset.
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    pc_out     = 32'd0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    err_set    = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (bus.branch_valid) begin
            // Taken branch squashes both younger stages, including a stalled
            // ID instruction; IF/ID loads the NOP.
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (bus.fetch_ready) begin
              pc_write = 1'b1;
              pc_out   = bus.branch_target;
              commit   = 1'b1;
            end else begin
              capture    = 1'b1;
              state_next = HOLD;
            end
          end else if (bus.hazard_stall) begin
            // Load-use bubble: freeze PC and IF/ID, inject NOP into ID/EX.
            idex_flush = 1'b1;
          end else if (bus.fetch_ready) begin
            pc_write   = 1'b1;
            pc_out     = bus.pc_plus4;
            ifid_write = 1'b1;
          end else begin
            // Fetch not accepted: nothing valid arrives, so load a NOP.
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          // Keep squashing until the held target is accepted by fetch.
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          err_set    = bus.branch_valid;
          if (bus.fetch_ready) begin
            pc_write   = 1'b1;
            pc_out     = held_target;
            commit     = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign bus.pc_write         = pc_write;
  assign bus.pc_out           = pc_out;
  assign bus.ifid_write       = ifid_write;
  assign bus.ifid_flush       = ifid_flush;
  assign bus.idex_flush       = idex_flush;
  assign bus.redirect_pending = (state == HOLD) && rst_n;
  assign bus.redirect_count   = redirect_count;
  assign bus.proto_err        = proto_err;

endmodule
